// File: rtl/seq_mult_shift_add_32bit_if.sv
// Bundles the multiplier's operand/handshake signals with the link to the
// external carry-look-ahead adder. The multiplier drives a/b/cin and reads
// sum/cout back in the same cycle.
interface seq_mult_shift_add_32bit_if #(
    parameter int WIDTH = 32
);
    // Request side
    logic               start;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;

    // Adder link
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    // Status and result
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    // Environment view: issues requests, owns the adder, observes the result
    modport master (
        output start,
        output multiplicand,
        output multiplier,
        output add_sum,
        output add_cout,
        input  add_a,
        input  add_b,
        input  add_cin,
        input  busy,
        input  done,
        input  product
    );

    // Multiplier view
    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        input  add_sum,
        input  add_cout,
        output add_a,
        output add_b,
        output add_cin,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/seq_mult_shift_add_32bit.sv
// Unsigned 32x32 -> 64 shift-add multiplier. Instead of owning an adder it
// borrows the parent's 32-bit CLA: A and M are presented to the adder, and
// the sum/carry come back combinationally. One multiplier bit is retired per
// clock, so an operation takes 32 RUN cycles followed by a one-cycle DONE.
module seq_mult_shift_add_32bit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    seq_mult_shift_add_32bit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               carry;
    logic [WIDTH-1:0]   a_pre;
    logic [WIDTH-1:0]   a_shift;
    logic [WIDTH-1:0]   q_shift;
    logic               accept;
    logic               last_iter;

    // One iteration: take the adder result when the current multiplier bit is
    // set (keeping its carry as the new MSB), then shift {C,A,Q} right by one
    always_comb begin
        carry = 1'b0;
        a_pre = a_q;
        if (q_q[0]) begin
            carry = bus.add_cout;
            a_pre = bus.add_sum;
        end
        a_shift = {carry, a_pre[WIDTH-1:1]};
        q_shift = {a_pre[0], q_q[WIDTH-1:1]};
    end

    // A new request is only honoured once the previous one has finished
    always_comb begin
        accept    = bus.start && ((state_q == IDLE) || (state_q == DONE));
        last_iter = (count_q == CNT_W'(WIDTH - 1));
    end

    // Next-state and datapath update; everything holds unless told otherwise
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    a_d     = '0;
                    q_d     = bus.multiplier;
                    m_d     = bus.multiplicand;
                    count_d = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_shift;
                q_d     = q_shift;
                count_d = count_q + CNT_W'(1);
                if (last_iter) begin
                    product_d = {a_shift, q_shift};
                    state_d   = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Adder operands come straight from the registers; no subtract path exists
    assign bus.add_a   = a_q;
    assign bus.add_b   = m_q;
    assign bus.add_cin = 1'b0;

    // Status is a pure decode of the state register, so busy and done are
    // mutually exclusive by construction
    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;

endmodule
